static_init_sequencer: RTL and testbench
========================================

Name: static_init_sequencer

Overview:
- Sequences initialisation of a bank of DEPTH static-value registers, then accumulates their sum.
- Rule: entry0 = seed; entry i = entry(i-1) + step.
- Once initialised, the bank is a shared read-only resource: a round-robin arbiter grants two requesters one read per cycle.
- Sits between the configuration/start logic and consumers that need ordered, dependency-correct initial values.

Parameters:
WIDTH, 8, data width of entries, seed, step and sum
DEPTH, 8, number of entries; power of two, >= 2
IDXW, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; begins init+sum when not busy
seed  input  WIDTH  value for entry 0, sampled with start
step  input  WIDTH  increment per entry, sampled with start
busy  output  1  high in INIT or SUM
done  output  1  high in READY (bank valid, sum valid)
sum_out  output  WIDTH  modulo-2^WIDTH sum of all entries, valid when done
req_a  input  1  read request, requester A
idx_a  input  IDXW  entry index, requester A
req_b  input  1  read request, requester B
idx_b  input  IDXW  entry index, requester B
gnt_a  output  1  combinational grant to A this cycle
gnt_b  output  1  combinational grant to B this cycle
rsp_valid  output  1  read data valid, one cycle after grant
rsp_src  output  1  0 = response for A, 1 = for B
rsp_data  output  WIDTH  entry value read

Behaviour:
- Reset (sync, rst high at edge):
  - State -> IDLE; busy=0, done=0, sum_out=0, rsp_valid=0, rsp_src=0, rsp_data=0.
  - RR pointer -> A; all entries cleared to 0.
  - rst overrides start and requests in the same cycle.
- States: IDLE, INIT, SUM, READY.
- IDLE/READY + start=1 at edge:
  - Latch seed and step; idx=0; go to INIT.
  - done drops on that edge; sum_out holds its old value until the new SUM completes.
- INIT, one entry per cycle:
  - mem[idx] = (idx==0) ? seed : prev + step, where prev is a running register holding the last written value.
  - All adds truncate to WIDTH (wrap).
  - After idx==DEPTH-1 is written, go to SUM with idx=0 and acc=0.
- SUM, one entry per cycle:
  - acc += mem[idx] (mod 2^WIDTH).
  - After idx==DEPTH-1, sum_out = final acc; go to READY.
- Latency: start sampled at edge k -> busy=1 from edge k through edge k+2*DEPTH; done=1 after edge k+2*DEPTH.
- start while busy is ignored; no restart, no error.
- Arbitration applies only in READY. In any other state gnt_a = gnt_b = 0 and requests are dropped, not queued.
- READY grant rules:
  - Only one requester asserting -> it is granted.
  - Both asserting -> grant goes to the RR pointer side; pointer flips to the other side after every grant to that side.
  - A single-requester grant also sets the pointer to the non-granted side.
- Response timing: rsp_valid=1 the cycle after a grant, with rsp_src = granted side and rsp_data = mem[granted idx]. Otherwise rsp_valid=0 and rsp_data/rsp_src hold their last values.
- start and requests together in READY: start wins. No grant that cycle; state goes to INIT.
- A response already launched from the previous cycle's grant still completes normally.
- rst mid-INIT/SUM: immediate return to IDLE; partial entries cleared; done stays 0 until a fresh start completes.

Test Plan:
- Basic sum: reset; start with seed=0x10, step=0x01 (DEPTH=8) -> busy high 16 cycles; done after edge k+16; sum_out=0x9C; read idx 3 via A -> rsp_data=0x13, rsp_src=0.
- Wrap-around: seed=0xF0, step=0x10 -> entries F0,00,10,20,30,40,50,60; sum_out=0x40; read idx 1 -> 0x00.
- Round-robin contention: in READY, hold req_a=req_b=1 (idx_a=0, idx_b=7) for 4 cycles after reset pointer=A -> grants A,B,A,B; responses 0x10,0x17,0x10,0x17 (basic config), each one cycle later.
- Gating:
  - Requests during INIT/SUM -> no grants, no rsp_valid.
  - start pulsed mid-INIT -> ignored; completion timing unchanged.
- Reset mid-operation: rst asserted at INIT cycle 4 -> next cycle busy=0, done=0, sum_out=0; a read after a subsequent full run returns the new values only.
- Restart from READY: second start with seed=0x01, step=0x02 -> done drops; sum_out stays 0x9C until completion, then 0x40 (1+3+…+15=64).

Source files
------------

// File: rtl/static_init_sequencer_if.sv
// Config/start, status and dual-requester read bus of the static init sequencer.
// The master side drives start/config and read requests; the slave side is the sequencer.
interface static_init_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IDXW = $clog2(DEPTH);

    logic             start;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] step;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;

    logic             req_a;
    logic [IDXW-1:0]  idx_a;
    logic             req_b;
    logic [IDXW-1:0]  idx_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             rsp_valid;
    logic             rsp_src;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output start, seed, step, req_a, idx_a, req_b, idx_b,
        input  busy, done, sum_out, gnt_a, gnt_b, rsp_valid, rsp_src, rsp_data
    );

    modport slave (
        input  start, seed, step, req_a, idx_a, req_b, idx_b,
        output busy, done, sum_out, gnt_a, gnt_b, rsp_valid, rsp_src, rsp_data
    );
endinterface

// File: rtl/static_init_sequencer.sv
// Fills a register bank with seed + i*step (one entry per cycle), sums it, then serves
// read-only accesses to two requesters through a round-robin arbiter.
module static_init_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input logic                      clk,
    input logic                      rst,
    static_init_sequencer_if.slave   bus
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StInit, StSum, StReady} state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             ptr_q, ptr_d;  // 0: A has priority on contention, 1: B
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_src_q, rsp_src_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             arb_en;
    logic             gnt_a, gnt_b;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] acc_next;

    // Arbitration only in READY; start or reset in the same cycle suppresses grants.
    always_comb begin
        arb_en = (state_q == StReady) && !bus.start && !rst;
        gnt_a  = arb_en && bus.req_a && (!bus.req_b || !ptr_q);
        gnt_b  = arb_en && bus.req_b && (!bus.req_a || ptr_q);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        step_d      = step_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        mem_d       = mem_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_src_d   = rsp_src_q;
        rsp_data_d  = rsp_data_q;
        init_val    = '0;
        acc_next    = '0;

        unique case (state_q)
            StIdle, StReady: begin
                if (bus.start) begin
                    seed_d  = bus.seed;
                    step_d  = bus.step;
                    idx_d   = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                init_val      = (idx_q == '0) ? seed_q : prev_q + step_q;
                mem_d[idx_q]  = init_val;
                prev_d        = init_val;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StSum;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            StSum: begin
                acc_next = acc_q + mem_q[idx_q];
                acc_d    = acc_next;
                if (idx_q == LastIdx) begin
                    sum_d   = acc_next;
                    idx_d   = '0;
                    state_d = StReady;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Bank is static in READY, so the granted entry can be captured directly.
        if (gnt_a) begin
            rsp_valid_d = 1'b1;
            rsp_src_d   = 1'b0;
            rsp_data_d  = mem_q[bus.idx_a];
            ptr_d       = 1'b1;
        end else if (gnt_b) begin
            rsp_valid_d = 1'b1;
            rsp_src_d   = 1'b1;
            rsp_data_d  = mem_q[bus.idx_b];
            ptr_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            seed_q      <= '0;
            step_q      <= '0;
            prev_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seed_q      <= seed_d;
            step_q      <= step_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.busy      = (state_q == StInit) || (state_q == StSum);
    assign bus.done      = (state_q == StReady);
    assign bus.sum_out   = sum_q;
    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_src   = rsp_src_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_static_init_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level
// behavioural model (countdown for the busy window, arithmetic bank contents, RR pointer).
module tb_static_init_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    static_init_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    static_init_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_seed, m_step, m_sum, m_rd;
    int         m_cnt;
    bit         m_ready, m_ptr, m_rv, m_rs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'h00;
        m_cnt = 0; m_ready = 0; m_sum = 8'h00; m_ptr = 0;
        m_rv = 0; m_rs = 0; m_rd = 8'h00;
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model at the edge.
    task automatic cycle(input bit i_rst, input bit i_start, input logic [7:0] i_seed,
                         input logic [7:0] i_step, input bit ra, input int ia,
                         input bit rb, input int ib);
        bit exp_ga, exp_gb;
        logic [7:0] s;
        rst       = i_rst;
        bus.start = i_start;
        bus.seed  = i_seed;
        bus.step  = i_step;
        bus.req_a = ra;
        bus.idx_a = 3'(ia);
        bus.req_b = rb;
        bus.idx_b = 3'(ib);
        #1;
        exp_ga = !i_rst && m_ready && !i_start && ra && (!rb || !m_ptr);
        exp_gb = !i_rst && m_ready && !i_start && rb && (!ra || m_ptr);
        check_eq("busy", 32'(bus.busy), 32'(m_cnt > 0));
        check_eq("done", 32'(bus.done), 32'(m_ready));
        check_eq("sum_out", 32'(bus.sum_out), 32'(m_sum));
        check_eq("gnt_a", 32'(bus.gnt_a), 32'(exp_ga));
        check_eq("gnt_b", 32'(bus.gnt_b), 32'(exp_gb));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
        check_eq("rsp_src", 32'(bus.rsp_src), 32'(m_rs));
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_rd));
        @(posedge clk);
        if (i_rst) begin
            model_reset();
        end else begin
            m_rv = exp_ga || exp_gb;
            if (exp_ga) begin
                m_rs = 0; m_rd = m_mem[ia]; m_ptr = 1;
            end else if (exp_gb) begin
                m_rs = 1; m_rd = m_mem[ib]; m_ptr = 0;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    s = 8'h00;
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        m_mem[i] = 8'(m_seed + 8'(i) * m_step);
                        s = 8'(s + m_mem[i]);
                    end
                    m_sum   = s;
                    m_ready = 1;
                end
            end else if (i_start) begin
                m_seed  = i_seed;
                m_step  = i_step;
                m_cnt   = 2 * DEPTH;
                m_ready = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic kick(input logic [7:0] sd, input logic [7:0] st);
        cycle(0, 1, sd, st, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.seed = 0; bus.step = 0;
        bus.req_a = 0; bus.idx_a = 0; bus.req_b = 0; bus.idx_b = 0;
        @(posedge clk);
        #1;
        model_reset();
        cycle(1, 1, 8'h55, 8'h01, 1, 2, 1, 3);  // reset dominates start and requests
        idle(2);

        // Basic sum, with requests while busy to confirm gating
        kick(8'h10, 8'h01);
        for (int i = 0; i < 2 * int'(DEPTH); i++) cycle(0, 0, 8'h00, 8'h00, 1, i, 1, 7 - i);
        check_eq("basic_sum", 32'(bus.sum_out), 32'h9C);
        cycle(0, 0, 8'h00, 8'h00, 1, 3, 0, 0);
        check_eq("basic_rd_a3", 32'(bus.rsp_data), 32'h13);
        check_eq("basic_rd_src", 32'(bus.rsp_src), 32'h0);

        // Round-robin after a fresh reset: A,B,A,B
        cycle(1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        kick(8'h10, 8'h01);
        idle(2 * DEPTH);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 8'h00, 8'h00, 1, 0, 1, 7);
            check_eq("rr_rsp", 32'(bus.rsp_data), (k % 2 == 1) ? 32'h17 : 32'h10);
        end
        idle(1);

        // Restart from READY: sum_out holds until completion
        kick(8'h01, 8'h02);
        check_eq("restart_done_drop", 32'(bus.done), 32'h0);
        idle(DEPTH);
        check_eq("restart_sum_hold", 32'(bus.sum_out), 32'h9C);
        idle(DEPTH);
        check_eq("restart_sum", 32'(bus.sum_out), 32'h40);

        // Wrap-around, with start pulsed mid-INIT (ignored)
        kick(8'hF0, 8'h10);
        idle(3);
        kick(8'h33, 8'h44);
        idle(2 * DEPTH - 4);
        check_eq("wrap_sum", 32'(bus.sum_out), 32'h40);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 1, 1);
        check_eq("wrap_rd_b1", 32'(bus.rsp_data), 32'h00);
        check_eq("wrap_rd_src", 32'(bus.rsp_src), 32'h1);

        // Reset at INIT cycle 4, then a fresh run
        kick(8'hA0, 8'h03);
        idle(3);
        cycle(1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_mid_sum", 32'(bus.sum_out), 32'h0);
        kick(8'h07, 8'h05);
        idle(2 * DEPTH);
        cycle(0, 0, 8'h00, 8'h00, 1, 2, 0, 0);
        check_eq("rst_fresh_rd", 32'(bus.rsp_data), 32'h11);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            cycle(r == 0, (r >= 1 && r <= 4), 8'($urandom), 8'($urandom),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
